// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions for the serial CRC generator and checker.
// Holds the default polynomial and seed, the checker state encoding, and a single-bit CRC step.
package crc_pkg;

    localparam int              CRC_W = 8;
    localparam logic [CRC_W-1:0] POLY  = 8'h07;
    localparam logic [CRC_W-1:0] INIT  = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One MSB-first step of the CRC register; the x^8 term is implicit.
    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0] crc,
        input logic             b,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = b ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/crc_check_if.sv
// Bit-stream input and per-frame result bundle between the bit sampler and crc_check.
// The master drives frames in; the slave (crc_check) reports the outcome.
interface crc_check_if #(
    parameter int LEN_W = 7
);

    logic                      start;
    logic [LEN_W-1:0]          frame_len;
    logic                      bit_valid;
    logic                      bit_in;
    logic                      busy;
    logic                      done;
    logic                      crc_ok;
    logic                      crc_err;
    logic                      stuff_err;
    logic [crc_pkg::CRC_W-1:0] calc_crc;
    logic [crc_pkg::CRC_W-1:0] rx_crc;

    modport master (
        output start, frame_len, bit_valid, bit_in,
        input  busy, done, crc_ok, crc_err, stuff_err, calc_crc, rx_crc
    );

    modport slave (
        input  start, frame_len, bit_valid, bit_in,
        output busy, done, crc_ok, crc_err, stuff_err, calc_crc, rx_crc
    );

endinterface

// File: rtl/crc_destuff.sv
// Removes CAN-style stuff bits from the wire stream and flags stuff violations.
// Run length spans the whole frame; o_stuff_next warns that the bit being accepted now makes a stuff bit due.
module crc_destuff #(
    parameter bit STUFF_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_bit_valid,
    input  logic i_bit_in,
    output logic o_data_valid,
    output logic o_data_bit,
    output logic o_stuff_err,
    output logic o_stuff_ok,
    output logic o_stuff_next
);

    logic [2:0] r_run;
    logic       r_prev;
    logic       w_is_stuff;
    logic       w_same;

    assign w_is_stuff   = STUFF_EN && (r_run == 3'd5);
    assign w_same       = (r_run != 3'd0) && (i_bit_in == r_prev);

    assign o_data_valid = i_bit_valid && !w_is_stuff;
    assign o_data_bit   = i_bit_in;
    assign o_stuff_err  = i_bit_valid && w_is_stuff && (i_bit_in == r_prev);
    assign o_stuff_ok   = i_bit_valid && w_is_stuff && (i_bit_in != r_prev);
    assign o_stuff_next = STUFF_EN && o_data_valid && w_same && (r_run == 3'd4);

    // NOTE: non-blocking assignments so r_run and r_prev both update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_run  <= 3'd0;
            r_prev <= 1'b0;
        end else if (i_bit_valid) begin
            if (w_is_stuff || !w_same)
                r_run <= 3'd1;
            else
                r_run <= r_run + 3'd1;
            r_prev <= i_bit_in;
        end
    end

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC-8 checker: destuffs the wire stream, recomputes the CRC over frame_len
// data bits, captures the 8-bit CRC field and reports ok / CRC error / stuff error per frame.
module crc_check
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY     = crc_pkg::POLY,
    parameter logic [CRC_W-1:0] INIT     = crc_pkg::INIT,
    parameter int               LEN_W    = 7,
    parameter bit               STUFF_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    crc_check_if.slave bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [CRC_W-1:0]   r_crc;
    logic [CRC_W-1:0]   r_rx_crc;
    logic [CRC_W-1:0]   w_rx_crc_nxt;
    logic               r_crc_ok;
    logic               r_crc_err;
    logic               r_stuff_err;

    logic               w_bit_acc;
    logic               w_dv;
    logic               w_db;
    logic               w_stuff_err;
    logic               w_stuff_ok;
    logic               w_stuff_next;
    logic               w_data_last;
    logic               w_crc_last;
    logic               w_stuff_wait;
    logic               w_enter_done;

    // Wire bits count only while a frame is being received and never in the start cycle.
    assign w_bit_acc = bus.bit_valid && !bus.start && ((r_state == DATA) || (r_state == CRC));

    crc_destuff #(
        .STUFF_EN (STUFF_EN)
    ) u_destuff (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (bus.start),
        .i_bit_valid  (w_bit_acc),
        .i_bit_in     (bus.bit_in),
        .o_data_valid (w_dv),
        .o_data_bit   (w_db),
        .o_stuff_err  (w_stuff_err),
        .o_stuff_ok   (w_stuff_ok),
        .o_stuff_next (w_stuff_next)
    );

    assign w_cnt_inc    = r_cnt + LEN_W'(1);
    assign w_data_last  = (w_cnt_inc == r_len);
    assign w_crc_last   = (r_cnt == LEN_W'(CRC_W - 1));
    assign w_stuff_wait = (r_cnt == LEN_W'(CRC_W));
    assign w_enter_done = (w_state_nxt == DONE) && (r_state != DONE);
    assign w_rx_crc_nxt = ((r_state == CRC) && w_dv) ? {r_rx_crc[CRC_W-2:0], w_db} : r_rx_crc;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = (bus.frame_len == '0) ? CRC : DATA;
        end else begin
            unique case (r_state)
                IDLE: w_state_nxt = IDLE;
                DATA: begin
                    if (w_stuff_err)
                        w_state_nxt = DONE;
                    else if (w_dv && w_data_last)
                        w_state_nxt = CRC;
                end
                CRC: begin
                    // A run of five ending on the last CRC bit still owes one stuff bit.
                    if (w_stuff_err)
                        w_state_nxt = DONE;
                    else if (w_dv && w_crc_last && !w_stuff_next)
                        w_state_nxt = DONE;
                    else if (w_stuff_ok && w_stuff_wait)
                        w_state_nxt = DONE;
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (r_state != IDLE);
        bus.done      = (r_state == DONE);
        bus.crc_ok    = r_crc_ok;
        bus.crc_err   = r_crc_err;
        bus.stuff_err = r_stuff_err;
        bus.calc_crc  = r_crc;
        bus.rx_crc    = r_rx_crc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_crc       <= '0;
            r_rx_crc    <= '0;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_stuff_err <= 1'b0;
        end else if (bus.start) begin
            r_len       <= bus.frame_len;
            r_cnt       <= '0;
            r_crc       <= INIT;
            r_rx_crc    <= '0;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_stuff_err <= 1'b0;
        end else begin
            if ((r_state == DATA) && w_dv) begin
                r_crc <= crc_step(r_crc, w_db, POLY);
                r_cnt <= w_data_last ? '0 : w_cnt_inc;
            end
            if ((r_state == CRC) && w_dv)
                r_cnt <= w_cnt_inc;
            r_rx_crc <= w_rx_crc_nxt;
            // The compare uses the CRC field including a final bit landing on this same edge.
            if (w_enter_done) begin
                r_stuff_err <= w_stuff_err;
                r_crc_ok    <= !w_stuff_err && (w_rx_crc_nxt == r_crc);
                r_crc_err   <= !w_stuff_err && (w_rx_crc_nxt != r_crc);
            end
        end
    end

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: table-driven frames plus hand-written sequences
// for trailing stuff bits, reset and restart aborts, and ignored bits.
module tb_crc_check;
    import crc_pkg::*;

    localparam int LEN_W = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_check_if #(.LEN_W(LEN_W)) bus ();

    crc_check #(
        .POLY     (8'h07),
        .INIT     (8'h00),
        .LEN_W    (LEN_W),
        .STUFF_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          len;
        int          nbits;
        logic [31:0] bits;
        int          gap;
        logic        ok;
        logic        err;
        logic        stf;
        logic [7:0]  calc;
        logic [7:0]  rx;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All drive tasks begin and end on a falling edge.
    task automatic pulse_start(input int len, input logic stray);
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(len);
        bus.bit_valid = stray;
        bus.bit_in    = stray;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        @(negedge clk);
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i]);
            if (gap > 0 && i > 0) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, ".done"},      bus.done,      1);
        check({tag, ".crc_ok"},    bus.crc_ok,    v.ok);
        check({tag, ".crc_err"},   bus.crc_err,   v.err);
        check({tag, ".stuff_err"}, bus.stuff_err, v.stf);
        check({tag, ".calc_crc"},  bus.calc_crc,  v.calc);
        check({tag, ".rx_crc"},    bus.rx_crc,    v.rx);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done, 0);
        check({tag, ".idle"},       bus.busy, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        pulse_start(v.len, 1'b0);
        send_bits(v.bits, v.nbits, v.gap);
        check_result(tag, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vec_t v;

        vecs[0] = '{len:8, nbits:16, bits:32'hA267, gap:0, ok:1'b1, err:1'b0, stf:1'b0, calc:8'h67, rx:8'h67};
        vecs[1] = '{len:8, nbits:16, bits:32'hA266, gap:0, ok:1'b0, err:1'b1, stf:1'b0, calc:8'h67, rx:8'h66};
        vecs[2] = '{len:8, nbits:19, bits:32'b0000010000010000010, gap:0, ok:1'b1, err:1'b0, stf:1'b0, calc:8'h00, rx:8'h00};
        vecs[3] = '{len:8, nbits:6,  bits:32'b000000, gap:0, ok:1'b0, err:1'b0, stf:1'b1, calc:8'h00, rx:8'h00};
        vecs[4] = '{len:0, nbits:9,  bits:32'b000001000, gap:0, ok:1'b1, err:1'b0, stf:1'b0, calc:8'h00, rx:8'h00};
        vecs[5] = '{len:0, nbits:9,  bits:32'b000001000, gap:3, ok:1'b1, err:1'b0, stf:1'b0, calc:8'h00, rx:8'h00};
        vecs[6] = '{len:8, nbits:18, bits:32'b111110111110110011, gap:0, ok:1'b1, err:1'b0, stf:1'b0, calc:8'hF3, rx:8'hF3};

        bus.start     = 1'b0;
        bus.frame_len = '0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset.busy",      bus.busy,      0);
        check("reset.done",      bus.done,      0);
        check("reset.crc_ok",    bus.crc_ok,    0);
        check("reset.crc_err",   bus.crc_err,   0);
        check("reset.stuff_err", bus.stuff_err, 0);
        check("reset.calc_crc",  bus.calc_crc,  0);
        check("reset.rx_crc",    bus.rx_crc,    0);

        // Bits offered while idle must be ignored.
        send_bits(32'hFF, 8, 0);
        check("idle.busy",     bus.busy, 0);
        check("idle.no_done",  done_cnt, 0);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Five zeros end on the last CRC bit: done must wait for the trailing stuff bit.
        pulse_start(2, 1'b0);
        send_bits(32'b00000100000, 11, 0);
        check("trail.no_early_done", bus.done, 0);
        check("trail.busy",          bus.busy, 1);
        repeat (3) @(negedge clk);
        check("trail.still_waiting", bus.done, 0);
        send_bit(1'b1);
        v = '{len:2, nbits:12, bits:32'h0, gap:0, ok:1'b1, err:1'b0, stf:1'b0, calc:8'h00, rx:8'h00};
        check_result("trail_ok", v);

        // Same frame with a wrong trailing stuff bit.
        pulse_start(2, 1'b0);
        send_bits(32'b00000100000, 11, 0);
        send_bit(1'b0);
        v = '{len:2, nbits:12, bits:32'h0, gap:0, ok:1'b0, err:1'b0, stf:1'b1, calc:8'h00, rx:8'h00};
        check_result("trail_bad", v);

        // Reset after four data bits, then a clean frame.
        d0 = done_cnt;
        pulse_start(8, 1'b0);
        send_bits(32'b1010, 4, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rst.busy",   bus.busy,   0);
        check("abort_rst.crc_ok", bus.crc_ok, 0);
        repeat (5) @(negedge clk);
        check("abort_rst.no_done", done_cnt, d0);
        run_vec("after_rst", vecs[0]);
        check("after_rst.one_done", done_cnt, d0 + 1);

        // Restart mid-frame; a bit offered with start must be ignored.
        d0 = done_cnt;
        pulse_start(8, 1'b0);
        send_bits(32'b111, 3, 0);
        check("abort_start.no_done", bus.done, 0);
        pulse_start(8, 1'b1);
        send_bits(32'hA267, 16, 0);
        check_result("restart", vecs[0]);
        check("restart.one_done", done_cnt, d0 + 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
